// File: rtl/uart_tx_ctrl_if.sv
// Host-side handshake and serial-line bundle for the UART transmit sequencer.
// The host (master) requests frames; the sequencer (slave) drives the line and status.
interface uart_tx_ctrl_if;
    logic       SendReq;
    logic [7:0] DataIn;
    logic [1:0] ParityType;
    logic       StopBits;
    logic       DataLength;
    logic       TxOut;
    logic       Busy;
    logic       Done;

    modport master (
        output SendReq,
        output DataIn,
        output ParityType,
        output StopBits,
        output DataLength,
        input  TxOut,
        input  Busy,
        input  Done
    );

    modport slave (
        input  SendReq,
        input  DataIn,
        input  ParityType,
        input  StopBits,
        input  DataLength,
        output TxOut,
        output Busy,
        output Done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: latches a byte plus line config on request and serialises one
// frame (start, 7/8 data LSB first, optional parity, 1/2 stop) with all outputs from flops.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = 10
) (
    input logic           Clock,
    input logic           Reset,
    uart_tx_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} stateT;

    stateT            stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [2:0]       bitIdxQ, bitIdxD;
    logic [7:0]       dataQ, dataD;
    logic             parityBitQ, parityBitD;
    logic             parityEnQ, parityEnD;
    logic             twoStopQ, twoStopD;
    logic             eightBitQ, eightBitD;
    logic             txOutQ, txOutD;
    logic             busyQ, busyD;
    logic             doneQ, doneD;

    logic             terminal;
    logic [7:0]       activeData;

    assign terminal   = (cntQ == CNT_W'(CLKS_PER_BIT - 1));
    assign activeData = bus.DataLength ? bus.DataIn : {1'b0, bus.DataIn[6:0]};

    // State register; outputs are registered from next-state values so TxOut leads no logic.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ     <= StIdle;
            cntQ       <= '0;
            bitIdxQ    <= '0;
            dataQ      <= '0;
            parityBitQ <= 1'b0;
            parityEnQ  <= 1'b0;
            twoStopQ   <= 1'b0;
            eightBitQ  <= 1'b0;
            txOutQ     <= 1'b1;
            busyQ      <= 1'b0;
            doneQ      <= 1'b0;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            bitIdxQ    <= bitIdxD;
            dataQ      <= dataD;
            parityBitQ <= parityBitD;
            parityEnQ  <= parityEnD;
            twoStopQ   <= twoStopD;
            eightBitQ  <= eightBitD;
            txOutQ     <= txOutD;
            busyQ      <= busyD;
            doneQ      <= doneD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        bitIdxD    = bitIdxQ;
        dataD      = dataQ;
        parityBitD = parityBitQ;
        parityEnD  = parityEnQ;
        twoStopD   = twoStopQ;
        eightBitD  = eightBitQ;

        if (stateQ != StIdle) begin
            cntD = terminal ? '0 : cntQ + CNT_W'(1);
        end

        unique case (stateQ)
            StIdle: begin
                cntD    = '0;
                bitIdxD = '0;
                if (bus.SendReq) begin
                    dataD      = activeData;
                    eightBitD  = bus.DataLength;
                    twoStopD   = bus.StopBits;
                    parityEnD  = (bus.ParityType == 2'b01) || (bus.ParityType == 2'b10);
                    // Odd parity sets the bit when the data holds an even number of ones.
                    parityBitD = (bus.ParityType == 2'b01) ? ~(^activeData) : ^activeData;
                    stateD     = StStart;
                end
            end
            StStart: begin
                if (terminal) begin
                    stateD = StData;
                end
            end
            StData: begin
                if (terminal) begin
                    if (bitIdxQ == (eightBitQ ? 3'd7 : 3'd6)) begin
                        bitIdxD = '0;
                        stateD  = parityEnQ ? StParity : StStop;
                    end else begin
                        bitIdxD = bitIdxQ + 3'd1;
                    end
                end
            end
            StParity: begin
                if (terminal) begin
                    stateD = StStop;
                end
            end
            StStop: begin
                // Bit index is reused to count the second stop bit.
                if (terminal) begin
                    if (twoStopQ && (bitIdxQ == 3'd0)) begin
                        bitIdxD = 3'd1;
                    end else begin
                        bitIdxD = '0;
                        stateD  = StIdle;
                    end
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_comb begin
        txOutD = 1'b1;
        unique case (stateD)
            StIdle:   txOutD = 1'b1;
            StStart:  txOutD = 1'b0;
            StData:   txOutD = dataD[bitIdxD];
            StParity: txOutD = parityBitD;
            StStop:   txOutD = 1'b1;
            default:  txOutD = 1'b1;
        endcase
        busyD = (stateD != StIdle);
        doneD = (stateQ == StStop) && (stateD == StIdle);
    end

    assign bus.TxOut = txOutQ;
    assign bus.Busy  = busyQ;
    assign bus.Done  = doneQ;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4: checks every cycle of each frame
// against hand-derived bit patterns, plus Done/Busy timing, busy-ignore and mid-frame reset.
module tb_uart_tx_ctrl;

    localparam int unsigned Cpb = 4;

    logic Clock = 1'b0;
    logic Reset;
    int   nTotal = 0;
    int   nBad   = 0;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(
        .CLKS_PER_BIT(Cpb),
        .CNT_W       (3)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Inputs change at a negedge; the following posedge is the accept edge.
    task automatic startFrame(input logic [7:0] data, input logic [1:0] ptype,
                              input logic stopb, input logic dlen);
        bus.DataIn     = data;
        bus.ParityType = ptype;
        bus.StopBits   = stopb;
        bus.DataLength = dlen;
        bus.SendReq    = 1'b1;
        @(posedge Clock);
    endtask

    // Called just after the accept edge; ends at the negedge inside the Done cycle.
    task automatic checkFrame(input string tag, input logic [11:0] bits, input int nBits,
                              input logic holdReq, input logic [7:0] midData,
                              input logic pulseReq);
        for (int i = 0; i < nBits * int'(Cpb); i++) begin
            @(negedge Clock);
            checkEq({tag, ".tx"}, 32'(bus.TxOut), 32'(bits[i / int'(Cpb)]));
            checkEq({tag, ".busy"}, 32'(bus.Busy), 32'd1);
            checkEq({tag, ".done"}, 32'(bus.Done), 32'd0);
            if (i == 0 && !holdReq) bus.SendReq = 1'b0;
            if (i == 10) begin
                bus.DataIn = midData;
                if (!holdReq) bus.StopBits = ~bus.StopBits;
            end
            if (pulseReq && (i == 6 || i == 10 || i == 14)) bus.SendReq = 1'b1;
            if (pulseReq && (i == 7 || i == 11 || i == 15)) bus.SendReq = 1'b0;
        end
        @(negedge Clock);
        checkEq({tag, ".doneCyc.done"}, 32'(bus.Done), 32'd1);
        checkEq({tag, ".doneCyc.busy"}, 32'(bus.Busy), 32'd0);
        checkEq({tag, ".doneCyc.tx"}, 32'(bus.TxOut), 32'd1);
    endtask

    task automatic idleCheck(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clock);
            checkEq({tag, ".idle.tx"}, 32'(bus.TxOut), 32'd1);
            checkEq({tag, ".idle.busy"}, 32'(bus.Busy), 32'd0);
            checkEq({tag, ".idle.done"}, 32'(bus.Done), 32'd0);
        end
    endtask

    initial begin
        Reset          = 1'b1;
        bus.SendReq    = 1'b0;
        bus.DataIn     = 8'h00;
        bus.ParityType = 2'b00;
        bus.StopBits   = 1'b0;
        bus.DataLength = 1'b1;
        repeat (2) @(negedge Clock);
        checkEq("reset.tx", 32'(bus.TxOut), 32'd1);
        checkEq("reset.busy", 32'(bus.Busy), 32'd0);
        checkEq("reset.done", 32'(bus.Done), 32'd0);
        Reset = 1'b0;
        idleCheck("postReset", 2);

        // 8N1 A5: 0,1,0,1,0,0,1,0,1,1
        startFrame(8'hA5, 2'b00, 1'b0, 1'b1);
        checkFrame("8N1_A5", 12'h34A, 10, 1'b0, 8'hFF, 1'b0);
        idleCheck("8N1_A5", 2);

        // 7E2 C1: bit 7 dropped, two ones -> even parity 0
        startFrame(8'hC1, 2'b10, 1'b1, 1'b0);
        checkFrame("7E2_C1", 12'h682, 11, 1'b0, 8'h3C, 1'b0);
        idleCheck("7E2_C1", 2);

        // 8O1 00: parity 1
        startFrame(8'h00, 2'b01, 1'b0, 1'b1);
        checkFrame("8O1_00", 12'h600, 11, 1'b0, 8'hFF, 1'b0);
        idleCheck("8O1_00", 2);

        // ParityType=11 behaves as no parity
        startFrame(8'h00, 2'b11, 1'b0, 1'b1);
        checkFrame("8N1_P11", 12'h200, 10, 1'b0, 8'hFF, 1'b0);
        idleCheck("8N1_P11", 2);

        // Held request: 55 then AA, separated only by the Done cycle
        startFrame(8'h55, 2'b00, 1'b0, 1'b1);
        checkFrame("b2b_55", 12'h2AA, 10, 1'b1, 8'hAA, 1'b0);
        @(posedge Clock);
        checkFrame("b2b_AA", 12'h354, 10, 1'b0, 8'h00, 1'b0);
        idleCheck("b2b_AA", 2);

        // Requests while busy are ignored
        startFrame(8'h0F, 2'b00, 1'b0, 1'b1);
        checkFrame("busyIgn", 12'h21E, 10, 1'b0, 8'hF0, 1'b1);
        idleCheck("busyIgn", 4);

        // Reset inside data bit 1 aborts the frame with no Done
        startFrame(8'hA5, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (i == 0) bus.SendReq = 1'b0;
        end
        Reset = 1'b1;
        @(negedge Clock);
        checkEq("midReset.tx", 32'(bus.TxOut), 32'd1);
        checkEq("midReset.busy", 32'(bus.Busy), 32'd0);
        checkEq("midReset.done", 32'(bus.Done), 32'd0);
        Reset = 1'b0;
        idleCheck("midReset", 3);
        startFrame(8'hA5, 2'b00, 1'b0, 1'b1);
        checkFrame("afterReset", 12'h34A, 10, 1'b0, 8'hFF, 1'b0);
        idleCheck("afterReset", 2);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
